// File: rtl/fp_itof32_seq_if.sv
// Handshake/data bundle for the sequential integer-to-FP32 converter.
// master drives the request (ld, operand, mode); slave returns the result.
interface fp_itof32_seq_if;
  logic        ld;
  logic        sgn_i;
  logic [2:0]  rm;
  logic [31:0] a;
  logic [31:0] o;
  logic        done;
  logic        busy;
  logic        inexact;

  modport master (
    output ld, sgn_i, rm, a,
    input  o, done, busy, inexact
  );

  modport slave (
    input  ld, sgn_i, rm, a,
    output o, done, busy, inexact
  );
endinterface

// File: rtl/fp_itof32_seq.sv
// Four-state sequential int32/uint32 to FP32 converter (IDLE->NORM->RND->DONE).
// Define FP_ITOF32_RM_EN to honour the rm port; otherwise it always rounds to nearest-even.
module fp_itof32_seq (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  fp_itof32_seq_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, NORM, RND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic        sgn_q, sgn_d;
  logic [2:0]  rm_q, rm_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] norm_q, norm_d;
  logic [31:0] res_q, res_d;
  logic        rinx_q, rinx_d;
  logic [31:0] o_q, o_d;
  logic        inexact_q, inexact_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // Normalisation helpers
  logic        neg;
  logic [31:0] mag;
  logic [4:0]  lz;

  // Rounding helpers
  logic [22:0] mant;
  logic        guard, sticky, inx, inc;
  logic [2:0]  rm_eff;
  logic [23:0] mant_sum;
  logic        carry;
  logic [7:0]  exp_r;
  logic [22:0] mant_r;
  logic        unused_ok;

  // Last set bit wins, so the result is 31 - msb; zero is flagged separately.
  function automatic logic [4:0] clz32(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

`ifdef FP_ITOF32_RM_EN
  assign rm_eff    = rm_q;
  assign unused_ok = norm_q[31];
`else
  assign rm_eff    = 3'd0;
  assign unused_ok = ^{norm_q[31], rm_q};
`endif

  always_comb begin
    neg = sgn_q & a_q[31];
    mag = neg ? (~a_q + 32'd1) : a_q;
    lz  = clz32(mag);
  end

  always_comb begin
    mant   = norm_q[30:8];
    guard  = norm_q[7];
    sticky = |norm_q[6:0];
    inx    = guard | sticky;
    case (rm_eff)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign_q & inx;
      3'd3:    inc = ~sign_q & inx;
      3'd4:    inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase
    mant_sum = {1'b0, mant} + {23'd0, inc};
    carry    = mant_sum[23];
    // Carry out of an all-ones mantissa bumps the exponent; max reachable is 159.
    exp_r    = exp_q + {7'd0, carry};
    mant_r   = carry ? 23'd0 : mant_sum[22:0];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    sgn_d     = sgn_q;
    rm_d      = rm_q;
    sign_d    = sign_q;
    zero_d    = zero_q;
    exp_d     = exp_q;
    norm_d    = norm_q;
    res_d     = res_q;
    rinx_d    = rinx_q;
    o_d       = o_q;
    inexact_d = inexact_q;
    done_d    = (state_q == DONE);
    busy_d    = (state_q != IDLE) || bus.ld;
    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          a_d     = bus.a;
          sgn_d   = bus.sgn_i;
          rm_d    = bus.rm;
          state_d = NORM;
        end
      end
      NORM: begin
        sign_d  = neg;
        zero_d  = (mag == 32'd0);
        norm_d  = mag << lz;
        exp_d   = 8'd158 - {3'd0, lz};
        state_d = RND;
      end
      RND: begin
        res_d   = zero_q ? 32'd0 : {sign_q, exp_r, mant_r};
        rinx_d  = zero_q ? 1'b0 : inx;
        state_d = DONE;
      end
      DONE: begin
        o_d       = res_q;
        inexact_d = rinx_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      sgn_q     <= 1'b0;
      rm_q      <= '0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      exp_q     <= '0;
      norm_q    <= '0;
      res_q     <= '0;
      rinx_q    <= 1'b0;
      o_q       <= '0;
      inexact_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      a_q       <= a_d;
      sgn_q     <= sgn_d;
      rm_q      <= rm_d;
      sign_q    <= sign_d;
      zero_q    <= zero_d;
      exp_q     <= exp_d;
      norm_q    <= norm_d;
      res_q     <= res_d;
      rinx_q    <= rinx_d;
      o_q       <= o_d;
      inexact_q <= inexact_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.inexact = inexact_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_fp_itof32_seq.sv
// Directed bench for fp_itof32_seq; expectations follow the rounding build
// selected by FP_ITOF32_RM_EN (default build rounds every mode as RNE).
module tb_fp_itof32_seq;

  logic clk;
  logic rst_n;
  logic ce;
  int   errors;
  int   checks;

  fp_itof32_seq_if bus();

  fp_itof32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FP_ITOF32_RM_EN
  localparam logic [31:0] E_FF_RTZ  = 32'h4F7FFFFF;
  localparam logic [31:0] E_RMM     = 32'h4B800001;
  localparam logic [31:0] E_RUP     = 32'h4B800001;
  localparam logic [31:0] E_T3_RTZ  = 32'h4B800001;
  localparam logic [31:0] E_NEG_RDN = 32'hCB800001;
`else
  localparam logic [31:0] E_FF_RTZ  = 32'h4F800000;
  localparam logic [31:0] E_RMM     = 32'h4B800000;
  localparam logic [31:0] E_RUP     = 32'h4B800000;
  localparam logic [31:0] E_T3_RTZ  = 32'h4B800002;
  localparam logic [31:0] E_NEG_RDN = 32'hCB800000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One conversion: ld at a negedge, then count ce-independent edges until done.
  task automatic convert(input string tag, input logic s, input logic [2:0] r,
                         input logic [31:0] av, input logic [31:0] exp_o,
                         input logic exp_inx, input int exp_lat,
                         input bit ld_busy, input bit stall);
    int lat;
    int extra;
    @(negedge clk);
    bus.sgn_i = s;
    bus.rm    = r;
    bus.a     = av;
    bus.ld    = 1'b1;
    @(posedge clk); #1;
    bus.ld = 1'b0;
    chk({tag, ".busy_accept"}, {31'd0, bus.busy}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (ld_busy && k == 1) begin
        bus.ld = 1'b1;
        bus.a  = ~av;
        bus.sgn_i = ~s;
      end
      if (ld_busy && k == 2) bus.ld = 1'b0;
      if (stall && k == 1) ce = 1'b0;
      if (stall && k == 3) ce = 1'b1;
      @(posedge clk); #1;
      if (bus.done === 1'b1) lat = k;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".o"}, bus.o, exp_o);
    chk({tag, ".inexact"}, {31'd0, bus.inexact}, {31'd0, exp_inx});
    chk({tag, ".busy_done"}, {31'd0, bus.busy}, 32'd1);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) extra++;
    end
    chk({tag, ".extra_done"}, 32'(extra), 32'd0);
    chk({tag, ".o_held"}, bus.o, exp_o);
    $display("txn %s: a=%h sgn=%0d rm=%0d -> o=%h inexact=%0d latency=%0d",
             tag, av, s, r, bus.o, bus.inexact, lat);
  endtask

  initial begin
    int extra;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    ce        = 1'b0;
    bus.ld    = 1'b0;
    bus.sgn_i = 1'b0;
    bus.rm    = 3'd0;
    bus.a     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.o", bus.o, 32'd0);
    chk("reset.done", {31'd0, bus.done}, 32'd0);
    chk("reset.busy", {31'd0, bus.busy}, 32'd0);
    chk("reset.inexact", {31'd0, bus.inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ce    = 1'b1;

    convert("u1_rne",      1'b0, 3'd0, 32'h00000001, 32'h3F800000, 1'b0, 3, 1'b0, 1'b0);
    convert("s_m1",        1'b1, 3'd0, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 3, 1'b0, 1'b0);
    convert("s_min",       1'b1, 3'd0, 32'h80000000, 32'hCF000000, 1'b0, 3, 1'b0, 1'b0);
    convert("u_ff_rne",    1'b0, 3'd0, 32'hFFFFFFFF, 32'h4F800000, 1'b1, 3, 1'b0, 1'b0);
    convert("u_ff_rtz",    1'b0, 3'd1, 32'hFFFFFFFF, E_FF_RTZ,     1'b1, 3, 1'b0, 1'b0);
    convert("tie_rne",     1'b0, 3'd0, 32'h01000001, 32'h4B800000, 1'b1, 3, 1'b0, 1'b0);
    convert("tie_rmm",     1'b0, 3'd4, 32'h01000001, E_RMM,        1'b1, 3, 1'b0, 1'b0);
    convert("tie_rup",     1'b0, 3'd3, 32'h01000001, E_RUP,        1'b1, 3, 1'b0, 1'b0);
    convert("odd_rne",     1'b0, 3'd0, 32'h01000003, 32'h4B800002, 1'b1, 3, 1'b0, 1'b0);
    convert("odd_rtz",     1'b0, 3'd1, 32'h01000003, E_T3_RTZ,     1'b1, 3, 1'b0, 1'b0);
    convert("odd_rm7",     1'b0, 3'd7, 32'h01000003, 32'h4B800002, 1'b1, 3, 1'b0, 1'b0);
    convert("neg_rdn",     1'b1, 3'd2, 32'hFEFFFFFF, E_NEG_RDN,    1'b1, 3, 1'b0, 1'b0);
    convert("neg_rup",     1'b1, 3'd3, 32'hFEFFFFFF, 32'hCB800000, 1'b1, 3, 1'b0, 1'b0);
    convert("u_big",       1'b0, 3'd0, 32'h80000000, 32'h4F000000, 1'b0, 3, 1'b0, 1'b0);
    convert("zero_rup",    1'b0, 3'd3, 32'h00000000, 32'h00000000, 1'b0, 3, 1'b0, 1'b0);
    convert("ld_busy",     1'b0, 3'd0, 32'h00000001, 32'h3F800000, 1'b0, 3, 1'b1, 1'b0);
    convert("ce_stall",    1'b1, 3'd0, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 5, 1'b0, 1'b1);

    // Reset while the conversion sits in RND: nothing may complete afterwards.
    @(negedge clk);
    bus.sgn_i = 1'b0;
    bus.rm    = 3'd0;
    bus.a     = 32'h00000003;
    bus.ld    = 1'b1;
    @(posedge clk); #1;
    bus.ld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.o", bus.o, 32'd0);
    chk("rst_mid.done", {31'd0, bus.done}, 32'd0);
    chk("rst_mid.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid.inexact", {31'd0, bus.inexact}, 32'd0);
    rst_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) extra++;
    end
    chk("rst_mid.no_done", 32'(extra), 32'd0);
    $display("txn rst_mid: reset in RND -> o=%h done_count=%0d", bus.o, extra);

    convert("after_rst",   1'b0, 3'd0, 32'h00000003, 32'h40400000, 1'b0, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
